key_event_queue: RTL and testbench

//  Downstream of the key scanner: captures each one-cycle key event (irq pulse + 32-bit word),

---
 rtl/key_pkg.sv | 37 +++
 rtl/key_evq_tick.sv | 47 ++++
 rtl/key_event_queue.sv | 147 ++++++++++++++
 tb/tb_key_event_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key-event definitions used by the key scanner, the event queue and
// the CPU-side decoder.
// Contents:
//   KEY_EV_W, KEY_EV_TYPE    event word width and the key-event type code
//   *_HI / *_LO              field ranges TYPE[31:24], TS[23:8], KEYS[7:0]
//   key_ev_t                 packed view of one event word
//   key_ev_stamp()           replaces the TS field of an event with a timestamp
package key_pkg;

  localparam int         KEY_EV_W    = 32;
  localparam logic [7:0] KEY_EV_TYPE = 8'd1;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 24;
  localparam int TS_HI   = 23;
  localparam int TS_LO   = 8;
  localparam int KEYS_HI = 7;
  localparam int KEYS_LO = 0;

  typedef struct packed {
    logic [7:0]  ev_type;
    logic [15:0] ts;
    logic [7:0]  keys;
  } key_ev_t;

  // The scanner leaves the middle field zero; whatever arrives there is
  // discarded and overwritten by the queue's own timestamp.
  function automatic logic [KEY_EV_W-1:0] key_ev_stamp(input logic [KEY_EV_W-1:0] ev,
                                                       input logic [15:0]         ts);
    key_ev_t s;
    s.ev_type = ev[TYPE_HI:TYPE_LO];
    s.ts      = ts;
    s.keys    = ev[KEYS_HI:KEYS_LO];
    return s;
  endfunction

endpackage

// File: rtl/key_evq_tick.sv
// Free-running timestamp source for the key event queue.
// A prescaler counts 0..TS_DIV-1; each time it reaches its terminal value the
// timestamp advances by one and wraps naturally at its full width.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-low reset (prescaler and timestamp to 0)
//   ts    out  current timestamp
module key_evq_tick #(
  parameter int TS_DIV = 1024,
  parameter int TS_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [TS_W-1:0] ts
);

  // One bit is kept even when TS_DIV==1 so the prescaler has a legal width;
  // in that case it sits at 0 and the timestamp advances every cycle.
  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    presc_d = presc_q;
    ts_d    = ts_q;
    if (presc_q == PW'(TS_DIV - 1)) begin
      presc_d = '0;
      ts_d    = ts_q + TS_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      ts_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ts_q    <= ts_d;
    end
  end

  assign ts = ts_q;

endmodule

// File: rtl/key_event_queue.sv
// Key event queue: buffers timestamped key events between the key scanner and
// the CPU. Each accepted event has its bits [23:8] replaced by the timestamp of
// the cycle it arrived in. The CPU pops one event per rd strobe; irq stays high
// while anything is waiting, and a dropped event sets a sticky overflow flag.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-low reset
//   ev_valid  in   one-cycle event strobe from the key scanner
//   ev_data   in   event word {type, 16'b0, keys}
//   rd        in   CPU pop strobe
//   flush     in   synchronous queue clear (beats rd and ev_valid)
//   ovf_clr   in   clears the sticky overflow flag
//   rd_data   out  last popped event {type, ts, keys}, held between pops
//   rd_valid  out  one-cycle pulse when rd_data has been updated
//   irq       out  high while the queue is non-empty (registered)
//   count     out  number of entries held
//   ovf       out  sticky flag: an event was dropped on a full queue
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TS_DIV = 1024,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  input  logic [KEY_EV_W-1:0]        ev_data,
  input  logic                       rd,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic [KEY_EV_W-1:0]        rd_data,
  output logic                       rd_valid,
  output logic                       irq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TS_W-1:0] ts;

  key_evq_tick #(
    .TS_DIV (TS_DIV),
    .TS_W   (TS_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .ts  (ts)
  );

  logic [KEY_EV_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       count_q, count_d;
  logic [KEY_EV_W-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                irq_q, irq_d;
  logic                ovf_q, ovf_d;

  logic                empty, full;
  logic                do_rd, do_wr, drop;
  logic [KEY_EV_W-1:0] wr_word;

  // The scanner's middle field carries no information.
  logic unused_ev_mid;
  assign unused_ev_mid = ^ev_data[TS_HI:TS_LO];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign wr_word = key_ev_stamp(ev_data, ts);

  // A full queue always has something to pop, so a coincident rd frees the
  // slot this same cycle and the write goes through. Flush suppresses both
  // the pop and the write, and nothing is counted as dropped while flushing.
  always_comb begin
    do_rd      = rd && !empty && !flush;
    do_wr      = ev_valid && !flush && (!full || rd);
    drop       = ev_valid && !flush && full && !rd;

    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = do_rd;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (do_wr) begin
        wp_d = wp_q + AW'(1);
      end
      if (do_rd) begin
        rp_d      = rp_q + AW'(1);
        rd_data_d = mem_q[rp_q];
      end
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end

    irq_d = (count_d != '0);

    // A drop in the same cycle as a clear must remain visible to software.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wp_q] <= wr_word;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;
   import key_pkg::*;

   localparam int DEPTH  = 8;
   localparam int TS_DIV = 4;
   localparam int CW     = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic          ev_valid = 1'b0;
   logic [31:0]   ev_data = '0;
   logic          rd = 1'b0;
   logic          flush = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          irq;
   logic [CW-1:0] count;
   logic          ovf;

   logic          bEvValid = 1'b0;
   logic [31:0]   bEvData = '0;
   logic          bRd = 1'b0;
   logic          bFlush = 1'b0;
   logic          bOvfClr = 1'b0;
   logic [31:0]   bRdData;
   logic          bRdValid;
   logic          bIrq;
   logic [CW-1:0] bCount;
   logic          bOvf;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;

   // Main instance uses a short prescaler so timestamps move quickly.
   key_event_queue #(.DEPTH(DEPTH), .TS_DIV(TS_DIV), .TS_W(16)) dutA (
      .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_data(ev_data), .rd(rd),
      .flush(flush), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
      .irq(irq), .count(count), .ovf(ovf)
   );

   // Second instance ticks every cycle so the 16-bit timestamp wrap is reachable.
   key_event_queue #(.DEPTH(DEPTH), .TS_DIV(1), .TS_W(16)) dutB (
      .clk(clk), .rst(rst), .ev_valid(bEvValid), .ev_data(bEvData), .rd(bRd),
      .flush(bFlush), .ovf_clr(bOvfClr), .rd_data(bRdData), .rd_valid(bRdValid),
      .irq(bIrq), .count(bCount), .ovf(bOvf)
   );

   always #5 clk = ~clk;

   // Reference behaviour of the main instance: a plain queue of event words,
   // timestamps taken as (cycles since reset release) / TS_DIV.
   logic [31:0] mq[$];
   logic [31:0] mRdData = '0;
   logic        mRdValid = 1'b0;
   logic        mOvf = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         mRdData  = '0;
         mRdValid = 1'b0;
         mOvf     = 1'b0;
         cyc      = 0;
      end else begin
         automatic logic dropped = 1'b0;
         mRdValid = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            if (rd && mq.size() > 0) begin
               mRdData  = mq.pop_front();
               mRdValid = 1'b1;
            end
            if (ev_valid) begin
               if (mq.size() < DEPTH)
                  mq.push_back({ev_data[31:24], 16'((cyc / TS_DIV) % 65536), ev_data[7:0]});
               else
                  dropped = 1'b1;
            end
         end
         if (dropped)
            mOvf = 1'b1;
         else if (ovf_clr)
            mOvf = 1'b0;
         cyc = cyc + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, away from the active edge, the main instance must agree with the model.
   always @(negedge clk) begin
      checkOutput("model rd_data", rd_data, mRdData);
      checkOutput("model rd_valid", 32'(rd_valid), 32'(mRdValid));
      checkOutput("model irq", 32'(irq), 32'(mq.size() != 0));
      checkOutput("model count", 32'(count), 32'(mq.size()));
      checkOutput("model ovf", 32'(ovf), 32'(mOvf));
   end

   // Waits for the next falling edge, then drives one cycle's worth of inputs.
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                                input logic f, input logic oc);
      @(negedge clk);
      ev_valid = v;
      ev_data  = d;
      rd       = r;
      flush    = f;
      ovf_clr  = oc;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] ev(input logic [7:0] keys);
      return {KEY_EV_TYPE, 16'hBEEF, keys};
   endfunction

   task automatic fillEvents(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b1, ev(first + 8'(i)), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held with a live event strobe; nothing may be captured.
      ev_valid = 1'b1;
      ev_data  = 32'h0100_0011;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      ev_valid = 1'b0;
      idle();
      checkOutput("reset count", 32'(count), 32'd0);
      checkOutput("reset irq", 32'(irq), 32'd0);
      checkOutput("reset ovf", 32'(ovf), 32'd0);
      checkOutput("reset rd_data", rd_data, 32'd0);

      // Event in cycle 10 after release carries ts=2.
      repeat (8) idle();
      applyStimulus(1'b1, 32'h0100_0005, 1'b0, 1'b0, 1'b0);
      checkOutput("irq before event", 32'(irq), 32'd0);
      idle();
      checkOutput("irq after event", 32'(irq), 32'd1);
      checkOutput("count after event", 32'(count), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("stamped word", rd_data, 32'h0100_0205);
      checkOutput("rd_valid pulse", 32'(rd_valid), 32'd1);
      checkOutput("irq after pop", 32'(irq), 32'd0);
      idle();
      checkOutput("rd_valid single", 32'(rd_valid), 32'd0);
      checkOutput("rd_data holds", rd_data, 32'h0100_0205);

      // Fill, overflow on the ninth, then drain in order.
      fillEvents(8'h01, 9);
      idle();
      checkOutput("full count", 32'(count), 32'd8);
      checkOutput("drop ovf", 32'(ovf), 32'd1);
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         if (j > 1) checkOutput("drain keys", 32'(rd_data[7:0]), 32'(j - 1));
      end
      idle();
      checkOutput("drain last", 32'(rd_data[7:0]), 32'd8);
      checkOutput("drain type", 32'(rd_data[31:24]), 32'(KEY_EV_TYPE));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("ovf cleared", 32'(ovf), 32'd0);

      // Full queue, simultaneous pop and push.
      fillEvents(8'h11, 8);
      applyStimulus(1'b1, ev(8'h19), 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("rw count", 32'(count), 32'd8);
      checkOutput("rw ovf", 32'(ovf), 32'd0);
      checkOutput("rw popped", 32'(rd_data[7:0]), 32'h11);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("rw last", 32'(rd_data[7:0]), 32'h19);
      checkOutput("rw empty", 32'(count), 32'd0);

      // Pop on empty; clear coincident with a drop.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("empty rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("empty rd_data", 32'(rd_data[7:0]), 32'h19);
      fillEvents(8'h21, 8);
      applyStimulus(1'b1, ev(8'h29), 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("set beats clear", 32'(ovf), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("clear alone", 32'(ovf), 32'd0);

      // Flush beats a coincident pop and push.
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      fillEvents(8'h41, 3);
      applyStimulus(1'b1, ev(8'h44), 1'b1, 1'b1, 1'b0);
      idle();
      checkOutput("flush count", 32'(count), 32'd0);
      checkOutput("flush irq", 32'(irq), 32'd0);
      checkOutput("flush rd_valid", 32'(rd_valid), 32'd0);
      fillEvents(8'h51, 1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("after flush keys", 32'(rd_data[7:0]), 32'h51);

      // Reset in the middle of a pop.
      fillEvents(8'h61, 2);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b0;
      rd = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      idle();
      checkOutput("mid-reset count", 32'(count), 32'd0);
      checkOutput("mid-reset irq", 32'(irq), 32'd0);
      checkOutput("mid-reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("mid-reset rd_data", rd_data, 32'd0);

      // Timestamp wrap on the every-cycle instance: ts=FFFF then ts=0000.
      while (cyc < 65535) @(negedge clk);
      bEvValid = 1'b1;
      bEvData  = ev(8'hA1);
      @(negedge clk);
      bEvData  = ev(8'hA2);
      @(negedge clk);
      bEvValid = 1'b0;
      bRd      = 1'b1;
      checkOutput("wrap count", 32'(bCount), 32'd2);
      @(negedge clk);
      checkOutput("wrap FFFF", bRdData, 32'h01FF_FFA1);
      checkOutput("wrap rd_valid", 32'(bRdValid), 32'd1);
      @(negedge clk);
      bRd = 1'b0;
      checkOutput("wrap 0000", bRdData, 32'h0100_00A2);
      @(negedge clk);
      checkOutput("wrap irq", 32'(bIrq), 32'd0);
      checkOutput("wrap ovf", 32'(bOvf), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
